led_fade_pwm: RTL and testbench

- Output stage that sits between the blink generator and the PMOD LED pin.
- Takes the blink block's on/off level as a request and drives the pin with PWM.
- Brightness ramps linearly up on request-high and down on request-low, instead of snapping on and off.
- Clocked on the board clock; reset comes from the board reset generator.

---
 rtl/led_fade_pwm.sv | 129 ++++++++++++
 tb/tb_led_fade_pwm.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/led_fade_pwm.sv
// ============================================================================
// Module   : led_fade_pwm
// Purpose  : PWM LED driver that ramps brightness linearly toward full or off
//            following a fade request. Optional build macro: LED_FADE_GAMMA_EN
//            (squared-level duty for perceptually linear fades).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_fade_pwm #(
  parameter int PWM_W    = 8,
  parameter int STEP_DIV = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             led,
  output logic [PWM_W-1:0] level,
  output logic [1:0]       state
);

  localparam int               SW          = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PWM_W-1:0] C_LVL_MAX   = '1;
  localparam logic [SW-1:0]    C_STEP_LAST = SW'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_RISE = 2'd1,
    S_ON   = 2'd2,
    S_FALL = 2'd3
  } state_t;

  state_t           r_state;
  logic [PWM_W-1:0] r_level;
  logic [PWM_W-1:0] r_pwm_cnt;
  logic [PWM_W-1:0] r_duty_q;
  logic [SW-1:0]    r_step_cnt;
  logic             r_led;
  logic             w_wrap;
  logic             w_tick;
  logic [PWM_W-1:0] w_duty_next;

  assign w_wrap = &r_pwm_cnt;
  assign w_tick = w_wrap && (r_step_cnt == C_STEP_LAST);

`ifdef LED_FADE_GAMMA_EN
  logic [2*PWM_W-1:0] w_sq;
  logic [PWM_W-1:0]   r_gamma;

  assign w_sq = {{PWM_W{1'b0}}, r_level} * {{PWM_W{1'b0}}, r_level};

  // Full brightness is forced so the top level stays constantly on.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_gamma <= '0;
    end else if (r_level == C_LVL_MAX) begin
      r_gamma <= C_LVL_MAX;
    end else begin
      r_gamma <= PWM_W'(w_sq >> PWM_W);
    end
  end

  assign w_duty_next = r_gamma;
`else
  assign w_duty_next = r_level;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pwm_cnt  <= '0;
      r_step_cnt <= '0;
      r_duty_q   <= '0;
      r_led      <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      r_led     <= (r_pwm_cnt < r_duty_q) || (&r_duty_q);
      if (w_wrap) begin
        r_duty_q   <= w_duty_next;
        r_step_cnt <= (r_step_cnt == C_STEP_LAST) ? '0 : r_step_cnt + 1'b1;
      end
    end
  end

  // Direction changes take priority over a coincident step tick.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_OFF;
      r_level <= '0;
    end else begin
      case (r_state)
        S_OFF: begin
          r_level <= '0;
          if (en) r_state <= S_RISE;
        end
        S_RISE: begin
          if (!en) begin
            r_state <= S_FALL;
          end else if (w_tick) begin
            if (r_level != C_LVL_MAX) r_level <= r_level + 1'b1;
            if (r_level >= C_LVL_MAX - 1'b1) r_state <= S_ON;
          end
        end
        S_ON: begin
          r_level <= C_LVL_MAX;
          if (!en) r_state <= S_FALL;
        end
        S_FALL: begin
          if (en) begin
            r_state <= S_RISE;
          end else if (w_tick) begin
            if (r_level != '0) r_level <= r_level - 1'b1;
            if (r_level <= {{(PWM_W-1){1'b0}}, 1'b1}) r_state <= S_OFF;
          end
        end
        default: begin
          r_state <= S_OFF;
          r_level <= '0;
        end
      endcase
    end
  end

  assign led   = r_led;
  assign level = r_level;
  assign state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_led_fade_pwm.sv
// ============================================================================
// Module   : tb_led_fade_pwm
// Purpose  : Self-checking bench for led_fade_pwm (PWM_W=4, STEP_DIV=2) with a
//            cycle-count based reference model. Honours LED_FADE_GAMMA_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_fade_pwm;

  localparam int PWM_W    = 4;
  localparam int STEP_DIV = 2;
  localparam int PERIOD   = 2 ** PWM_W;
  localparam int LMAX     = PERIOD - 1;
`ifdef LED_FADE_GAMMA_EN
  localparam bit GAMMA = 1'b1;
`else
  localparam bit GAMMA = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             en;
  logic             led;
  logic [PWM_W-1:0] level;
  logic [1:0]       state;

  led_fade_pwm #(.PWM_W(PWM_W), .STEP_DIV(STEP_DIV)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .led   (led),
    .level (level),
    .state (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: everything derived from cycles elapsed since reset release.
  int m_cyc, m_level, m_state, m_duty, m_gam, hi_cnt;
  bit m_led;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cyc=%0d: actual=%0d required=%0d", name, m_cyc, act, exp);
    end
  endtask

  task automatic model_step();
    int  pwm, nl, ns;
    bit  wrap, tick;
    if (!rst) begin
      m_cyc = 0; m_level = 0; m_state = 0; m_duty = 0; m_gam = 0; m_led = 1'b0;
    end else begin
      pwm  = m_cyc % PERIOD;
      wrap = (pwm == LMAX);
      tick = wrap && ((m_cyc / PERIOD) % STEP_DIV == STEP_DIV - 1);
      m_led = (pwm < m_duty) || (m_duty == LMAX);
      if (wrap) m_duty = GAMMA ? m_gam : m_level;
      m_gam = (m_level == LMAX) ? LMAX : (m_level * m_level) / PERIOD;
      nl = m_level;
      ns = m_state;
      case (m_state)
        0: if (en) ns = 1;
        1: if (!en) ns = 3;
           else if (tick) begin
             nl = (m_level < LMAX) ? m_level + 1 : LMAX;
             if (nl == LMAX) ns = 2;
           end
        2: if (!en) ns = 3;
        default: if (en) ns = 1;
           else if (tick) begin
             nl = (m_level > 0) ? m_level - 1 : 0;
             if (nl == 0) ns = 0;
           end
      endcase
      m_level = nl;
      m_state = ns;
      m_cyc++;
    end
  endtask

  // One clock: model follows the edge, DUT is compared at the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (m_cyc % PERIOD == 1) hi_cnt = int'(led);
    else hi_cnt += int'(led);
    chk("model_led",   {31'd0, led},   {31'd0, m_led});
    chk("model_level", 32'(level),     32'(m_level));
    chk("model_state", 32'(state),     32'(m_state));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cycle();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_led",   {31'd0, led}, 32'd0);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    hi_cnt = 0;
    m_cyc = 0; m_level = 0; m_state = 0; m_duty = 0; m_gam = 0; m_led = 1'b0;
    cycle();
    do_reset();

    // Idle with request low, one reset pulse mid-run.
    for (int i = 0; i < 200; i++) begin
      if (i == 100) do_reset();
      cycle();
    end
    chk("idle_level", 32'(level), 32'd0);
    chk("idle_state", 32'(state), 32'd0);

    // Full rise from reset release, then full fall.
    do_reset();
    en = 1'b1;
    while (m_cyc < 1200) begin
      if (m_cyc == 560) en = 1'b0;
      cycle();
      if (m_cyc == 1)   chk("lit_rise_state", 32'(state), 32'd1);
      if (m_cyc == 32)  chk("lit_level1", 32'(level), 32'd1);
      if (m_cyc == 480) chk("lit_on_level", 32'(level), 32'd15);
      if (m_cyc == 480) chk("lit_on_state", 32'(state), 32'd2);
      if (m_cyc == 561) chk("lit_fall_state", 32'(state), 32'd3);
      if (m_cyc == 1120) chk("lit_off_state", 32'(state), 32'd0);
      if (GAMMA) begin
        if (m_cyc == 16 * 8)  chk("lit_gamma_l3_highs", 32'(hi_cnt), 32'd0);
        if (m_cyc == 16 * 18) chk("lit_gamma_l8_highs", 32'(hi_cnt), 32'd4);
      end else begin
        if (m_cyc == 16 * 12) chk("lit_l5_highs", 32'(hi_cnt), 32'd5);
      end
      if (m_cyc == 16 * 32) chk("lit_l15_highs", 32'(hi_cnt), 32'd16);
    end

    // Direction change coinciding with a tick at level 7.
    do_reset();
    en = 1'b1;
    while (m_cyc < 400) begin
      if (m_cyc == 255) en = 1'b0;
      if (m_cyc == 300) en = 1'b1;
      cycle();
      if (m_cyc == 256) chk("lit_toggle_state", 32'(state), 32'd3);
      if (m_cyc == 256) chk("lit_toggle_level", 32'(level), 32'd7);
      if (m_cyc == 288) chk("lit_fall_step", 32'(level), 32'd6);
      if (m_cyc == 301) chk("lit_resume_state", 32'(state), 32'd1);
      if (m_cyc == 301) chk("lit_resume_level", 32'(level), 32'd6);
    end
    do_reset();

    // Randomised request changes with occasional resets.
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 59) == 0) en = ~en;
      rst = ($urandom_range(0, 799) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
